// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file with ROB rename-tag busy tracking.
// Define RF_BYPASS_EN to forward a matching same-cycle commit into the operand queries.
module reg_status_file #(
   parameter int REG_NUM = 32,
   parameter int ROB_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rdy,
   input  logic             clear,
   input  logic             issue_en,
   input  logic [4:0]       issue_rd,
   input  logic [ROB_W-1:0] issue_rob_id,
   input  logic             commit_en,
   input  logic [4:0]       commit_rd,
   input  logic [ROB_W-1:0] commit_rob_id,
   input  logic [31:0]      commit_val,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   output logic [31:0]      rs1_val,
   output logic [31:0]      rs2_val,
   output logic             rs1_busy,
   output logic             rs2_busy,
   output logic [ROB_W-1:0] rs1_tag,
   output logic [ROB_W-1:0] rs2_tag,
   output logic             query_hazard
);
   logic [31:0]      val [REG_NUM];
   logic [ROB_W-1:0] tag [REG_NUM];
   logic [REG_NUM-1:0] busy;
   logic [4:0]       ids   [2];
   logic [31:0]      q_val [2];
   logic             q_busy[2];
   logic [ROB_W-1:0] q_tag [2];
   logic [1:0]       match;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= '0;
         for (int i = 0; i < REG_NUM; i++) begin
            val[i] <= '0;
            tag[i] <= '0;
         end
      end else if (rdy) begin
         if (commit_en && commit_rd != 5'd0) begin
            val[commit_rd] <= commit_val;
            if (tag[commit_rd] == commit_rob_id) busy[commit_rd] <= 1'b0;
         end
         // later assignments win, giving issue and then clear priority over commit
         if (issue_en && issue_rd != 5'd0 && !clear) begin
            busy[issue_rd] <= 1'b1;
            tag[issue_rd]  <= issue_rob_id;
         end
         if (clear) busy <= '0;
      end
   end
   assign ids[0] = rs1_id;
   assign ids[1] = rs2_id;
   for (genvar g = 0; g < 2; g++) begin : g_query
      logic zero;
      assign zero     = ids[g] == 5'd0;
      assign match[g] = commit_en && busy[ids[g]] && tag[ids[g]] == commit_rob_id;
      assign q_tag[g] = zero ? '0 : tag[ids[g]];
`ifdef RF_BYPASS_EN
      logic byp;
      assign byp       = !zero && match[g] && commit_rd == ids[g];
      assign q_val[g]  = zero ? 32'd0 : byp ? commit_val : val[ids[g]];
      assign q_busy[g] = !zero && busy[ids[g]] && !byp;
`else
      assign q_val[g]  = zero ? 32'd0 : val[ids[g]];
      assign q_busy[g] = !zero && busy[ids[g]];
`endif
   end
`ifdef RF_BYPASS_EN
   assign query_hazard = 1'b0;
   logic unused_match;
   assign unused_match = ^match;
`else
   assign query_hazard = |match;
`endif
   assign rs1_val  = q_val[0];
   assign rs2_val  = q_val[1];
   assign rs1_busy = q_busy[0];
   assign rs2_busy = q_busy[1];
   assign rs1_tag  = q_tag[0];
   assign rs2_tag  = q_tag[1];
endmodule
